// File: rtl/rock_pkg.sv
// rock_pkg: shared types and constants for the rocking controller stages.
//   rock_state_e : wave generator state encoding (IDLE, UP, DOWN, PARK)
//   A_W, F_W     : amplitude / frequency code widths
//   center_of()  : centre position value for a given position width
//   CENTER       : centre position at the default 8-bit position width
package rock_pkg;

  localparam int A_W       = 3;
  localparam int F_W       = 3;
  localparam int POS_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    PARK = 2'd3
  } rock_state_e;

  function automatic int center_of(input int pos_w);
    return 1 << (pos_w - 1);
  endfunction

  localparam int CENTER = center_of(POS_W_DEF);

endpackage

// File: rtl/rock_tick_gen.sv
// rock_tick_gen: free-running prescaler, counts 0..PRESCALE-1 and wraps.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset (counter -> 0)
//   tick_o : high for the one clock in which the count equals PRESCALE-1
module rock_tick_gen #(
  parameter int PRESCALE = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (tick_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/rock_wave_gen.sv
// rock_wave_gen: triangle-wave cradle position setpoint generator.
//   clk         : system clock
//   reset       : asynchronous active-low reset
//   A           : amplitude code (0 = stop), half-swing = A*AMP_STEP
//   F           : frequency code, position step per motion tick = F+1
//   err         : controller error, parks the cradle at centre
//   pos         : position setpoint, CENTER + offset
//   dir         : 1 while moving down (DOWN, or PARK from above centre)
//   cycle_pulse : one-clock pulse at each upward centre crossing
//   at_center   : offset == 0
//   pwm         : PWM of pos when ROCK_PWM_OUT_EN is defined, else 0
//
// state | meaning
// IDLE  | parked at centre, A/F latched each tick, starts when A != 0
// UP    | offset rising toward +h
// DOWN  | offset falling toward -h
// PARK  | error recovery, offset walks 1 per tick back to centre
module rock_wave_gen
  import rock_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int POS_W    = 8,
  parameter int AMP_STEP = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [A_W-1:0]   A,
  input  logic [F_W-1:0]   F,
  input  logic             err,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             cycle_pulse,
  output logic             at_center,
  output logic             pwm
);

  if (PRESCALE < 2) begin : g_chk_prescale
    $error("rock_wave_gen: PRESCALE must be at least 2");
  end
  if (7 * AMP_STEP >= (1 << (POS_W - 1))) begin : g_chk_amp
    $error("rock_wave_gen: 7*AMP_STEP must be below 2^(POS_W-1)");
  end

  // Two bits of headroom so offset +/- step never wraps before the compare.
  localparam int               OW       = POS_W + 2;
  localparam logic [POS_W-1:0] CENTER_P = POS_W'(center_of(POS_W));

  logic tick;

  rock_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk_i  (clk),
    .rst_ni (reset),
    .tick_o (tick)
  );

  rock_state_e             state_q, state_d;
  logic signed [POS_W:0]   offset_q, offset_d;
  logic [A_W-1:0]          a_l_q, a_l_d;
  logic [F_W-1:0]          f_l_q, f_l_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    dir_q, dir_d;
  logic                    pulse_q, pulse_d;
  logic                    at_center_q, at_center_d;

  logic signed [OW-1:0]    off_x, step_x, h_x, neg_h, n_up, n_dn, n_park;

  assign off_x  = {offset_q[POS_W], offset_q};
  assign step_x = OW'(f_l_q) + OW'(1);
  assign h_x    = OW'(a_l_q) * OW'(AMP_STEP);
  assign neg_h  = -h_x;
  assign n_up   = off_x + step_x;
  assign n_dn   = off_x - step_x;
  assign n_park = offset_q[POS_W] ? off_x + OW'(1) : off_x - OW'(1);

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    a_l_d    = a_l_q;
    f_l_d    = f_l_q;
    pulse_d  = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          a_l_d = A;
          f_l_d = F;
          if (!err && (A != '0)) state_d = UP;
        end
        UP: begin
          // Error entry only changes state; the walk home starts next tick.
          if (err) begin
            state_d = PARK;
          end else if (n_up >= h_x) begin
            offset_d = h_x[POS_W:0];
            state_d  = DOWN;
          end else if (offset_q[POS_W] && !n_up[OW-1]) begin
            offset_d = '0;
            pulse_d  = 1'b1;
            a_l_d    = A;
            f_l_d    = F;
            if (A == '0) state_d = IDLE;
          end else begin
            offset_d = n_up[POS_W:0];
          end
        end
        DOWN: begin
          if (err) begin
            state_d = PARK;
          end else if (n_dn <= neg_h) begin
            offset_d = neg_h[POS_W:0];
            state_d  = UP;
          end else if (!offset_q[POS_W] && (offset_q != '0) &&
                       (n_dn[OW-1] || (n_dn == '0))) begin
            offset_d = '0;
            a_l_d    = A;
            f_l_d    = F;
            if (A == '0) state_d = IDLE;
          end else begin
            offset_d = n_dn[POS_W:0];
          end
        end
        PARK: begin
          if (offset_q == '0) begin
            state_d = IDLE;
          end else begin
            offset_d = n_park[POS_W:0];
            if (n_park == '0) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    dir_d       = (state_d == DOWN) ||
                  ((state_d == PARK) && !offset_d[POS_W] && (offset_d != '0));
    at_center_d = (offset_d == '0);
    pos_d       = CENTER_P + offset_d[POS_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      a_l_q       <= '0;
      f_l_q       <= '0;
      pos_q       <= CENTER_P;
      dir_q       <= 1'b0;
      pulse_q     <= 1'b0;
      at_center_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      a_l_q       <= a_l_d;
      f_l_q       <= f_l_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      pulse_q     <= pulse_d;
      at_center_q <= at_center_d;
    end
  end

  assign pos         = pos_q;
  assign dir         = dir_q;
  assign cycle_pulse = pulse_q;
  assign at_center   = at_center_q;

`ifdef ROCK_PWM_OUT_EN
  logic [POS_W-1:0] pwm_cnt_q;
  logic             pwm_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + 1'b1;
      pwm_q     <= (pwm_cnt_q < pos_q);
    end
  end

  assign pwm = pwm_q;
`else
  assign pwm = 1'b0;
`endif

endmodule

// File: doc/rock_wave_gen.md
Name: rock_wave_gen

Overview:
- Downstream stage of the rocking controller; consumes the 3-bit amplitude code A and frequency code F produced by the amplitude/frequency stage, plus the combined error flag.
- Generates a triangle-wave cradle position setpoint for the motor driver.
- A/F changes take effect only at a center crossing, so the cradle never jerks.
- Emits one pulse per completed rocking period for upstream pacing logic.

Parameters:
- PRESCALE, 50000: clocks per motion tick (≥2).
- POS_W, 8: position output width.
- AMP_STEP, 16: half-swing per amplitude code unit. Elaboration check: 7*AMP_STEP < 2^(POS_W-1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- A  in  3  amplitude code; 0 = stop
- F  in  3  frequency code; position step per tick = F+1
- err  in  1  controller error; forces park at center
- pos  out  POS_W  position setpoint, CENTER = 2^(POS_W-1)
- dir  out  1  1 = moving down (DOWN/PARK from above), 0 otherwise
- cycle_pulse  out  1  one-clock pulse per full period
- at_center  out  1  offset == 0
- pwm  out  1  PWM of pos (optional feature)

Behaviour:
- Prescaler counts 0..PRESCALE-1 and wraps. tick = (count == PRESCALE-1), combinational.
- All motion registers update on the clock edge that ends the tick cycle. Latency from a tick to the new pos: that same edge.
- Internal registers:
  - signed offset, POS_W+1 bits
  - latched A_l, F_l
  - h = A_l*AMP_STEP
  - step = F_l+1
- pos = CENTER + offset, registered.
- Reset values: state IDLE, offset 0, pos CENTER (128 at default), A_l = F_l = 0, dir 0, cycle_pulse 0, at_center 1, pwm 0, prescaler 0.
- States: IDLE, UP, DOWN, PARK. Every transition happens on a tick only.
- IDLE (offset 0): latch A, F.
  - If err: stay.
  - Else if A != 0: go UP. Offset is not moved on this tick.
- UP: n = offset+step.
  - If n ≥ h: offset = h, go DOWN.
  - Else if offset < 0 and n ≥ 0: snap offset = 0, pulse cycle_pulse, relatch A/F. If the new A == 0: go IDLE, else stay UP.
  - Else: offset = n.
- DOWN: n = offset-step.
  - If n ≤ -h: offset = -h, go UP.
  - Else if offset > 0 and n ≤ 0: snap offset = 0, relatch A/F. If the new A == 0: go IDLE. No cycle_pulse on this crossing.
  - Else: offset = n.
- PARK: offset moves 1 toward 0 per tick. At 0: go IDLE.
- err sampled at tick in UP/DOWN: go PARK immediately. err takes priority over limit and crossing handling on that tick.
- err deasserted during PARK: PARK still completes to center before restarting.
- A/F input changes between crossings are ignored until the next relatch.
- Amplitude decrease at center: new h applies from 0 outward; no overshoot.
- h < step: clamp at ±h still holds.
- cycle_pulse is registered, high exactly one clock.
- reset mid-swing: immediate return to reset values; pos jumps to CENTER.

Optional Feature:
- ROCK_PWM_OUT_EN defined:
  - free-running POS_W-bit counter
  - pwm = (counter < pos), registered
  - reset counter 0, pwm 0
- Not defined: pwm tied 0; counter not synthesised.

Decomposition:
- Package rock_pkg holds:
  - state enum (IDLE, UP, DOWN, PARK)
  - CENTER, derived from POS_W
  - code widths A_W = F_W = 3
- Sub-module rock_tick_gen: parameterised prescaler producing tick. It is reusable by the other controller stages.

Test Plan (PRESCALE=4, defaults otherwise):
- Reset low mid-run → pos=128, at_center=1, cycle_pulse=0 asynchronously; state IDLE after release.
- A=1, F=0, err=0 → first movement one tick after leaving IDLE. Peak pos 144, trough 112. Period 64 ticks = 256 clocks between cycle_pulses.
- A=7, F=7 → h=112, step 8. pos clamps exactly at 240 and 16. Center crossings snap to 128.
- Change A 1→3 while pos=140 rising → swing unchanged (peak 144) until the next center crossing, then peak 176.
- Assert err at pos=142 → dir=1, pos decreases by 1 per tick to 128, stays there while err is held. Release err with A=1 → swing restarts.
- Set A=0 while rocking → motion continues to the next crossing, then holds at 128 in IDLE with no further cycle_pulse. With ROCK_PWM_OUT_EN defined, pwm duty = 128/256.
